// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and helpers for seq_alu.
// SEQ_ALU_DIV_EN enables the DIVU/REMU opcodes.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_REMU  = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_iter(
    input logic [3:0] op
  );
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_MULHU)
        || is_div(op);
`else
    return (op == OP_MUL) || (op == OP_MULHU);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu.
// master = issuer/consumer, slave = the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  overflow, carry, zero,
    input  negative, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output overflow, carry, zero,
    output negative, err
  );
endinterface

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier / restoring divider, 1 bit per cycle.
// Ports: start_i/div_i/a_i/b_i in; busy_o, done_o, lo_o/hi_o (next-state) out.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH:0]   sum;

`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;
`endif

  // mul: {acc,lo} holds {partial, multiplier}
  assign sum = {1'b0, acc_q}
             + {1'b0, lo_q[0] ? opd_q : '0};

`ifdef SEQ_ALU_DIV_EN
  // div: acc = remainder, lo = dividend -> quotient
  assign shl   = {acc_q, lo_q[WIDTH-1]};
  assign trial = shl - {1'b0, opd_q};
`endif

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    lo_d  = lo_q;
    opd_d = opd_q;
`ifdef SEQ_ALU_DIV_EN
    div_d = div_q;
`endif
    if (start_i) begin
      cnt_d = CW'(WIDTH);
      acc_d = '0;
      lo_d  = div_i ? a_i : b_i;
      opd_d = div_i ? b_i : a_i;
`ifdef SEQ_ALU_DIV_EN
      div_d = div_i;
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
`ifdef SEQ_ALU_DIV_EN
      if (div_q) begin
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shl[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
`else
      acc_d = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      opd_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
`ifdef SEQ_ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign busy_o = (cnt_q != '0);
  // last iteration happens on the edge that follows
  assign done_o = (cnt_q == CW'(1));
  assign lo_o   = lo_d;
  assign hi_o   = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready in and out; MUL/MULHU (and DIVU/REMU
// when SEQ_ALU_DIV_EN) iterate. Ports: clk, rst (async low), bus (slave).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             v_q, c_q, z_q, n_q, err_q;

  logic             accept;
  logic             iter_op;
  logic             it_busy, it_done;
  logic [WIDTH-1:0] it_lo, it_hi;

  logic [WIDTH-1:0] alu_res;
  logic             alu_v, alu_c, alu_err;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;

  logic             ld;
  logic [WIDTH-1:0] res_in;
  logic             v_in, c_in, err_in;

  assign accept  = bus.in_valid && (state_q == ST_IDLE);
  assign iter_op = is_iter(bus.op);

  seq_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk_i   (clk),
    .rst_ni  (rst),
    .start_i (accept && iter_op),
    .div_i   (is_div(bus.op)),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .busy_o  (it_busy),
    .done_o  (it_done),
    .lo_o    (it_lo),
    .hi_o    (it_hi)
  );

  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w = {1'b0, bus.a} + {1'b0, ~bus.b}
               + (WIDTH+1)'(1);
  assign sh    = bus.b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
               && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1])
               && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = WIDTH'($signed(bus.a)
                                < $signed(bus.b));
      OP_SLTU: alu_res = WIDTH'(bus.a < bus.b);
      OP_SLL:  alu_res = bus.a << sh;
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(bus.a) >>> sh);
      // iterative ops never load from here
      default: alu_err = !is_iter(bus.op);
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)
        state_d = iter_op ? ST_BUSY : ST_DONE;
      ST_BUSY: if (it_done) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    res_in = alu_res;
    v_in   = alu_v;
    c_in   = alu_c;
    err_in = alu_err;
    if (state_q == ST_BUSY) begin
      ld     = it_done;
      c_in   = 1'b0;
      err_in = 1'b0;
      v_in   = 1'b0;
      unique case (1'b1)
        (op_q == OP_MUL): begin
          res_in = it_lo;
          v_in   = |it_hi;
        end
        (op_q == OP_DIVU): res_in = it_lo;
        default:           res_in = it_hi;
      endcase
    end else if (accept && !iter_op) begin
      ld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= bus.op;
      if (ld) begin
        result_q <= res_in;
        v_q      <= v_in;
        c_q      <= c_in;
        z_q      <= (res_in == '0);
        n_q      <= res_in[WIDTH-1];
        err_q    <= err_in;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = v_q;
  assign bus.carry     = c_q;
  assign bus.zero      = z_q;
  assign bus.negative  = n_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: random + directed ops vs arithmetic model.
// Honours SEQ_ALU_DIV_EN in the reference model.
module tb_seq_alu;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] r;
    logic        v, c, z, n, e;
    int          lat;
    time         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   rnd_rdy = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus();

  seq_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  function automatic exp_t model(
    input logic [3:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    exp_t        e;
    longint      sx, sy, sr;
    logic [63:0] p;
    logic [32:0] u;
    e.op = o; e.r = '0; e.v = 0; e.c = 0;
    e.e = 0; e.lat = 1; e.t = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = 64'(x) * 64'(y);
    case (o)
      4'h0: begin
        u = {1'b0, x} + {1'b0, y};
        e.r = u[31:0]; e.c = u[32];
        sr = sx + sy;
        e.v = (sr != longint'($signed(e.r)));
      end
      4'h1: begin
        e.r = x - y; e.c = (x >= y);
        sr = sx - sy;
        e.v = (sr != longint'($signed(e.r)));
      end
      4'h2: e.r = x & y;
      4'h3: e.r = x | y;
      4'h4: e.r = x ^ y;
      4'h5: e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'h6: e.r = x << y[4:0];
      4'h7: e.r = x >> y[4:0];
      4'h8: e.r = 32'(sx >>> y[4:0]);
      4'h9: e.r = (x < y) ? 32'd1 : 32'd0;
      4'hA: begin
        e.r = p[31:0]; e.v = (p[63:32] != 0);
        e.lat = 33;
      end
      4'hB: begin
        e.r = p[63:32]; e.lat = 33;
      end
`ifdef SEQ_ALU_DIV_EN
      4'hC: begin
        e.r = (y == 0) ? 32'hFFFF_FFFF : x / y;
        e.lat = 33;
      end
      4'hD: begin
        e.r = (y == 0) ? x : x % y;
        e.lat = 33;
      end
`endif
      default: e.e = 1;
    endcase
    e.z = (e.r == 0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic issue(
    input logic [3:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    int   n = 0;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = o; bus.a = x; bus.b = y;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%h", o);
    end else begin
      e = model(o, x, y);
      e.t = $time;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  // random consumer back-pressure, changed just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: peek every valid cycle (stability), pop on handshake
  initial begin
    bit   seen = 0;
    int   lat;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output got=%h", bus.result);
        end else begin
          e = q[0];
          if (!seen) begin
            seen = 1;
            lat = int'(($time - e.t) / 10);
            checks++;
            if (lat != e.lat) begin
              failures++;
              $display("FAIL latency op=%h got=%0d exp=%0d",
                       e.op, lat, e.lat);
            end
          end
          checks++;
          if (bus.result !== e.r) begin
            failures++;
            $display("FAIL result op=%h got=%h exp=%h",
                     e.op, bus.result, e.r);
          end
          checks++;
          if ({bus.overflow, bus.carry, bus.zero,
               bus.negative, bus.err}
              !== {e.v, e.c, e.z, e.n, e.e}) begin
            failures++;
            $display("FAIL flags op=%h got=%b exp=%b", e.op,
              {bus.overflow, bus.carry, bus.zero,
               bus.negative, bus.err},
              {e.v, e.c, e.z, e.n, e.e});
          end
          checks++;
          if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_done got=%b exp=0",
                     bus.in_ready);
          end
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0;
    bus.out_ready = 1'b1;
    #23;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", 32'({bus.overflow, bus.carry,
        bus.zero, bus.negative, bus.err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    issue(4'h0, 32'h7FFF_FFFF, 32'd1);
    issue(4'h1, 32'd5, 32'd5);
    issue(4'h5, 32'hFFFF_FFFF, 32'd1);
    issue(4'h9, 32'hFFFF_FFFF, 32'd1);
    issue(4'h8, 32'h8000_0000, 32'd4);
    issue(4'hA, 32'hFFFF_FFFF, 32'd2);
    issue(4'hB, 32'hFFFF_FFFF, 32'd2);
    issue(4'hC, 32'd100, 32'd7);
    issue(4'hD, 32'd100, 32'd7);
    issue(4'hC, 32'd9, 32'd0);
    issue(4'hD, 32'd9, 32'd0);
    issue(4'hE, 32'd1, 32'd2);

    // back-pressure while DONE, with ignored request pulses
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'h0, 32'd10, 32'd20);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk("bp_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.op = 4'h1;
      bus.a = 32'd99;
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    issue(4'h3, 32'h0F0F_0000, 32'h0000_F0F0);

    // async reset in the middle of a multiply
    issue(4'hA, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_result", bus.result, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(bus.in_ready), 1);
    issue(4'h0, 32'd2, 32'd3);

    // randomized traffic with random consumer stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 40));
        1: y = 32'd0;
        default: ;
      endcase
      issue(4'($urandom_range(0, 15)), x, y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Executes the legacy single-cycle operations plus SRA, SLTU, an iterative shift-add multiply and an optional iterative restoring divide.
- Uses a valid/ready handshake on both input and output.
- Sits between the decode/issue stage and writeback; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0] (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block idle and able to accept.
- op  input  4  opcode (encoding below).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- overflow  output  1  V flag.
- carry  output  1  C flag.
- zero  output  1  Z flag.
- negative  output  1  N flag.
- err  output  1  illegal or disabled opcode.

Behaviour:
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 MUL (low word), 1011 MULHU (high word, unsigned), 1100 DIVU, 1101 REMU, 1110/1111 illegal.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept occurs when in_valid && in_ready at a rising edge (cycle k). op, a and b are captured then; later input changes have no effect.
- Single-cycle ops and illegal ops: IDLE->DONE; out_valid high in cycle k+1.
- MUL/MULHU/DIVU/REMU: IDLE->BUSY with iteration counter = WIDTH. One iteration per BUSY cycle. BUSY->DONE when the counter reaches 0; out_valid high in cycle k+WIDTH+1.
- DONE: result and flags held stable until out_ready. On out_valid && out_ready -> IDLE; next accept is possible in the following cycle. Maximum throughput is 1 op per 2 cycles.
- in_valid while BUSY/DONE is ignored.
- Flags, computed on the final result:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD: C = carry-out, V = signed overflow.
  - SUB: computed as a+~b+1; C = carry-out (1 = no borrow), V = signed overflow.
  - MUL: V = 1 if the upper product half is nonzero, C = 0.
  - All other ops: V = C = 0.
- Shifts use b[SHW-1:0]; SRA sign-fills.
- Divide by zero: DIVU result = all ones, REMU result = a; V = C = 0, err = 0.
- Illegal opcode: result = 0, flags 0 except Z = 1, err = 1.
- Reset (async, any state, including mid-iteration): state IDLE, result 0, all flags 0, err 0, out_valid 0, counter 0. in_ready = 1 once reset is released; no accept occurs while rst is low.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: DIVU/REMU execute as an iterative restoring divider, latency WIDTH+1.
- Undefined: no divider logic is built. 1100/1101 behave as illegal opcodes (single-cycle, err = 1, result 0).

Decomposition:
- Package seq_alu_pkg: opcode localparams (OP_ADD..OP_REMU), state enum/localparams (ST_IDLE, ST_BUSY, ST_DONE), helper function is_iter(op).
- Sub-module seq_alu_iter: the shift-add multiplier and restoring-divider datapath, including the iteration counter and a done pulse.
- Top seq_alu: handshake FSM, single-cycle ops, flag generation and output registers.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, accept cycle k -> out_valid at k+1; result 0x80000000, V=1, C=0, N=1, Z=0.
- SUB a=5, b=5 -> result 0, Z=1, C=1, V=0. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MUL a=0xFFFFFFFF, b=2 -> out_valid at k+33; result 0xFFFFFFFE, V=1. MULHU same operands -> 0x00000001.
- With SEQ_ALU_DIV_EN:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
  - Without macro: op 1100 -> err=1, result 0, out_valid at k+1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, in_valid pulses ignored. Release out_ready -> IDLE; a new op is accepted next cycle.
- Drive rst low during BUSY cycle 10 of a MUL -> out_valid=0 and result=0 immediately. After release, in_ready=1 and a fresh ADD 2+3 returns 5.
